// File: rtl/vm1_lite.sv
// vm1_lite: reduced 1801VM1-style CPU core with a multiplexed active-low Q-bus.
// After power-up it reads the start vector, then fetches and executes a small
// instruction set: HALT, NOP, BR, and JMP on PC-relative modes. Read-only bus master.
// Ports:
//   pin_clk / pin_dclo        clock, asynchronous active-high reset
//   pin_aclo_n                power-OK; core starts once it is seen high
//   pin_ad_n[15:0]            inverted address/data, driven or Z
//   pin_sync_n/din_n/dout_n   open-drain bus strobes (dout never asserted)
//   pin_rply_n                slave reply
//   pin_bsy_n, pin_sel_n[1:0] open-drain busy and start-vector select
//   pin_init_n                open-drain system init
//   pin_wtbt_n, pin_dmgo_n    constant 1, and DMA grant passthrough
//   pin_pa_n, pin_irq_n, pin_virq_n, pin_sp_n  accepted but unused
//   pin_dmr_n, pin_sack_n, pin_iako_n          always Z
module vm1_lite #(
    parameter int unsigned VM1_CORE_MULG_VERSION = 0,
    parameter int unsigned RPLY_TIMEOUT          = 64
) (
    input  logic        pin_clk,
    input  logic        pin_dclo,
    input  logic        pin_aclo_n,
    input  logic [1:0]  pin_pa_n,
    input  logic        pin_irq_n,
    input  logic        pin_virq_n,
    input  logic        pin_sp_n,
    inout  wire  [15:0] pin_ad_n,
    output wire         pin_sync_n,
    output wire         pin_din_n,
    output wire         pin_dout_n,
    output logic        pin_wtbt_n,
    input  logic        pin_rply_n,
    output wire         pin_dmr_n,
    output wire         pin_sack_n,
    output wire         pin_iako_n,
    input  logic        pin_dmgi_n,
    output logic        pin_dmgo_n,
    output wire  [1:0]  pin_sel_n,
    output wire         pin_bsy_n,
    output wire         pin_init_n
);

    localparam int unsigned AW        = 16;
    localparam int unsigned TW        = $clog2(RPLY_TIMEOUT + 1);
    localparam logic [AW-1:0] VEC_ADDR  = 16'o177716;
    localparam logic [AW-1:0] VEC_MASK  = 16'o177400;
    localparam logic [AW-1:0] EVEN_MASK = 16'o177776;
    localparam logic [AW-1:0] PSW_RESET = 16'o000340;

    typedef enum logic [3:0] {
        S_WAIT_ACLO,
        S_POWERUP,
        S_START,
        S_ADDR,
        S_SYNC,
        S_DIN,
        S_RPLY,
        S_DECODE,
        S_HALTED
    } state_t;

    // What the word returned by the current read is used for
    typedef enum logic [1:0] {
        RQ_VECTOR,
        RQ_FETCH,
        RQ_IND,
        RQ_IDX
    } req_t;

    state_t          state_q, state_d;
    req_t            req_q, req_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [AW-1:0]   psw_q, psw_d;
    logic [AW-1:0]   data_q, data_d;
    logic [AW-1:0]   ad_out_q, ad_out_d;
    logic            ad_oe_q, ad_oe_d;
    logic            sync_q, sync_d;
    logic            din_q, din_d;
    logic            bsy_q, bsy_d;
    logic            sel_q, sel_d;
    logic            init_q, init_d;
    logic            aclo_s1_q, aclo_s2_q;
    logic [TW-1:0]   tmo_q, tmo_d;

    logic            start_rd;
    logic [AW-1:0]   start_addr;
    req_t            start_req;
    logic            tmo_last;

    // Power-OK synchronizer
    always_ff @(posedge pin_clk or posedge pin_dclo) begin
        if (pin_dclo) begin
            aclo_s1_q <= 1'b0;
            aclo_s2_q <= 1'b0;
        end else begin
            aclo_s1_q <= pin_aclo_n;
            aclo_s2_q <= aclo_s1_q;
        end
    end

    // State and datapath registers; reset releases every strobe at once
    always_ff @(posedge pin_clk or posedge pin_dclo) begin
        if (pin_dclo) begin
            state_q  <= S_WAIT_ACLO;
            req_q    <= RQ_VECTOR;
            pc_q     <= '0;
            psw_q    <= PSW_RESET;
            data_q   <= '0;
            ad_out_q <= '0;
            ad_oe_q  <= 1'b0;
            sync_q   <= 1'b0;
            din_q    <= 1'b0;
            bsy_q    <= 1'b0;
            sel_q    <= 1'b0;
            init_q   <= 1'b1;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            pc_q     <= pc_d;
            psw_q    <= psw_d;
            data_q   <= data_d;
            ad_out_q <= ad_out_d;
            ad_oe_q  <= ad_oe_d;
            sync_q   <= sync_d;
            din_q    <= din_d;
            bsy_q    <= bsy_d;
            sel_q    <= sel_d;
            init_q   <= init_d;
            tmo_q    <= tmo_d;
        end
    end

    assign tmo_last = (tmo_q == TW'(RPLY_TIMEOUT - 1));

    // Next-state, bus sequencing and instruction execution
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        pc_d       = pc_q;
        psw_d      = psw_q;
        data_d     = data_q;
        ad_out_d   = ad_out_q;
        ad_oe_d    = ad_oe_q;
        sync_d     = sync_q;
        din_d      = din_q;
        bsy_d      = bsy_q;
        sel_d      = sel_q;
        init_d     = init_q;
        tmo_d      = tmo_q;
        start_rd   = 1'b0;
        start_addr = pc_q;
        start_req  = RQ_FETCH;

        case (state_q)
            S_WAIT_ACLO: begin
                if (aclo_s2_q) begin
                    init_d  = 1'b0;
                    state_d = S_POWERUP;
                end
            end
            S_POWERUP: begin
                start_rd   = 1'b1;
                start_addr = VEC_ADDR;
                start_req  = RQ_VECTOR;
            end
            S_START: begin
                start_rd = 1'b1;
            end
            S_ADDR: begin
                sync_d  = 1'b1;
                state_d = S_SYNC;
            end
            S_SYNC: begin
                ad_oe_d = 1'b0;
                din_d   = 1'b1;
                tmo_d   = '0;
                state_d = S_DIN;
            end
            // Waiting for the reply to go active
            S_DIN: begin
                if (!pin_rply_n) begin
                    data_d  = ~pin_ad_n;
                    din_d   = 1'b0;
                    tmo_d   = '0;
                    state_d = S_RPLY;
                end else if (tmo_last) begin
                    state_d = S_HALTED;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            // Waiting for the reply to go inactive, then use the word
            S_RPLY: begin
                if (pin_rply_n) begin
                    sync_d = 1'b0;
                    bsy_d  = 1'b0;
                    sel_d  = 1'b0;
                    case (req_q)
                        RQ_VECTOR: begin
                            pc_d    = data_q & VEC_MASK;
                            state_d = S_START;
                        end
                        RQ_FETCH: begin
                            pc_d    = pc_q + 16'd2;
                            state_d = S_DECODE;
                        end
                        RQ_IND: begin
                            pc_d    = data_q & EVEN_MASK;
                            state_d = S_START;
                        end
                        default: begin
                            // pc_q still points at X; target is the address after X plus X
                            pc_d    = (pc_q + 16'd2 + data_q) & EVEN_MASK;
                            state_d = S_START;
                        end
                    endcase
                end else if (tmo_last) begin
                    state_d = S_HALTED;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            // data_q holds the instruction, pc_q already points past it
            S_DECODE: begin
                start_rd = 1'b1;
                if (data_q == 16'o000000) begin
                    start_rd = 1'b0;
                    state_d  = S_HALTED;
                end else if (data_q[15:8] == 8'h01) begin
                    pc_d = pc_q + {{7{data_q[7]}}, data_q[7:0], 1'b0};
                end else if (data_q[15:6] == 10'b0000000001) begin
                    if (data_q[2:0] != 3'd7) begin
                        start_rd = 1'b0;
                        state_d  = S_HALTED;
                    end else begin
                        case (data_q[5:3])
                            // (PC) and (PC)+ both land on the current PC
                            3'd1, 3'd2: pc_d = pc_q;
                            3'd3:       start_req = RQ_IND;
                            3'd4:       pc_d = pc_q - 16'd2;
                            3'd6:       start_req = RQ_IDX;
                            default: begin
                                start_rd = 1'b0;
                                state_d  = S_HALTED;
                            end
                        endcase
                    end
                end
                start_addr = pc_d;
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_HALTED;
            end
        endcase

        // Abort on reply timeout: drop everything
        if (state_d == S_HALTED) begin
            ad_oe_d = 1'b0;
            sync_d  = 1'b0;
            din_d   = 1'b0;
            bsy_d   = 1'b0;
            sel_d   = 1'b0;
        end

        // Address phase of a new read
        if (start_rd) begin
            ad_oe_d  = 1'b1;
            ad_out_d = ~start_addr;
            bsy_d    = 1'b1;
            sel_d    = (start_addr == VEC_ADDR);
            req_d    = start_req;
            state_d  = S_ADDR;
        end
    end

    assign pin_ad_n   = ad_oe_q ? ad_out_q : {AW{1'bz}};
    assign pin_sync_n = sync_q ? 1'b0 : 1'bz;
    assign pin_din_n  = din_q  ? 1'b0 : 1'bz;
    assign pin_bsy_n  = bsy_q  ? 1'b0 : 1'bz;
    assign pin_init_n = init_q ? 1'b0 : 1'bz;
    assign pin_sel_n  = {1'bz, (sel_q ? 1'b0 : 1'bz)};
    assign pin_dout_n = 1'bz;
    assign pin_dmr_n  = 1'bz;
    assign pin_sack_n = 1'bz;
    assign pin_iako_n = 1'bz;
    assign pin_wtbt_n = 1'b1;
    assign pin_dmgo_n = pin_dmgi_n;

    logic unused_ok;
    assign unused_ok = ^{pin_pa_n, pin_irq_n, pin_virq_n, pin_sp_n, psw_q,
                         VM1_CORE_MULG_VERSION[0]};

endmodule

// File: tb/tb_vm1_lite.sv
// Directed bench for vm1_lite: a small memory slave on the bus, a cycle monitor
// logging start addresses, and hand-computed expected fetch sequences.
module tb_vm1_lite;

    logic clk = 1'b0;
    logic dclo;
    logic aclo_n;
    logic dmgi_n;
    logic [1:0] pa_n = 2'b11;
    logic irq_n = 1'b1, virq_n = 1'b1, sp_n = 1'b1;

    tri1        sync_n, din_n, dout_n, dmr_n, sack_n, iako_n, bsy_n, init_n;
    tri1 [1:0]  sel_n;
    tri1 [15:0] ad_bus;
    wire        wtbt_n, dmgo_n, rply_n;

    // Slave model state
    logic        slave_en, fast, alt, slow_rply;
    int          slow_cnt;
    logic [15:0] rd_data, vec_val;
    logic [15:0] mem_a [4];
    logic [15:0] mem_d [4];

    // Monitor state
    logic [15:0] addr_log [$];
    logic        sel_log  [$];
    logic        cyc_ok   [$];
    int          ncyc;
    logic        prev_bsy, prev_sync, saw_din, bsy_held;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign ad_bus = (slave_en && din_n == 1'b0) ? ~rd_data : 16'hzzzz;
    assign rply_n = !slave_en ? 1'b1 : (fast ? din_n : slow_rply);

    vm1_lite #(.VM1_CORE_MULG_VERSION(0), .RPLY_TIMEOUT(64)) dut (
        .pin_clk(clk), .pin_dclo(dclo), .pin_aclo_n(aclo_n), .pin_pa_n(pa_n),
        .pin_irq_n(irq_n), .pin_virq_n(virq_n), .pin_sp_n(sp_n),
        .pin_ad_n(ad_bus), .pin_sync_n(sync_n), .pin_din_n(din_n),
        .pin_dout_n(dout_n), .pin_wtbt_n(wtbt_n), .pin_rply_n(rply_n),
        .pin_dmr_n(dmr_n), .pin_sack_n(sack_n), .pin_iako_n(iako_n),
        .pin_dmgi_n(dmgi_n), .pin_dmgo_n(dmgo_n), .pin_sel_n(sel_n),
        .pin_bsy_n(bsy_n), .pin_init_n(init_n)
    );

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        logic [15:0] r;
        r = 16'o000240;
        if (a == 16'o177716) r = vec_val;
        for (int i = 0; i < 4; i++) if (mem_a[i] == a) r = mem_d[i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %o expected %o", tag, got, exp);
        end
    endtask

    // Slow slave: reply two clocks after din, release once din is gone
    always @(negedge clk) begin
        if (din_n == 1'b0) begin
            slow_cnt++;
            if (slow_cnt >= 2) slow_rply = 1'b0;
        end else begin
            slow_cnt  = 0;
            slow_rply = 1'b1;
        end
    end

    // Bus cycle monitor
    always @(negedge clk) begin
        if (dclo) begin
            prev_bsy  = 1'b1;
            prev_sync = 1'b1;
        end else begin
            if (bsy_n == 1'b0 && prev_bsy == 1'b1) begin
                addr_log.push_back(~ad_bus);
                sel_log.push_back(sel_n[0]);
                rd_data  = mem_rd(~ad_bus);
                saw_din  = 1'b0;
                bsy_held = 1'b1;
            end
            if (bsy_n == 1'b0 && din_n == 1'b0) saw_din = 1'b1;
            if (sync_n == 1'b0 && bsy_n != 1'b0) bsy_held = 1'b0;
            if (sync_n == 1'b1 && prev_sync == 1'b0) begin
                cyc_ok.push_back(saw_din && bsy_held && din_n == 1'b1 && bsy_n == 1'b1);
                ncyc++;
                if (alt) fast = ~fast;
            end
            prev_bsy  = bsy_n;
            prev_sync = sync_n;
        end
    end

    task automatic set_mem(input int i, input logic [15:0] a, input logic [15:0] d);
        mem_a[i] = a;
        mem_d[i] = d;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4; i++) set_mem(i, 16'o177777, 16'o000240);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        dclo   = 1'b1;
        aclo_n = 1'b0;
        addr_log.delete();
        sel_log.delete();
        cyc_ok.delete();
        ncyc = 0;
        repeat (10) @(negedge clk);
        check({tag, "_rst_init"}, 32'(init_n), 32'd0);
        check({tag, "_rst_sync"}, 32'(sync_n), 32'd1);
        check({tag, "_rst_bsy"}, 32'(bsy_n), 32'd1);
        check({tag, "_rst_ad"}, 32'(ad_bus), 32'hFFFF);
        dclo = 1'b0;
        repeat (10) @(negedge clk);
        check({tag, "_preaclo_init"}, 32'(init_n), 32'd0);
        check({tag, "_preaclo_sync"}, 32'(sync_n), 32'd1);
        aclo_n = 1'b1;
    endtask

    task automatic wait_cycles(input int n, input string tag);
        int budget;
        budget = 40 * n + 100;
        while (ncyc < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check({tag, "_cycles_done"}, 32'(ncyc >= n), 32'd1);
    endtask

    initial begin
        int cnt;
        dclo = 1'b1; aclo_n = 1'b0; dmgi_n = 1'b1;
        slave_en = 1'b1; fast = 1'b1; alt = 1'b0; slow_rply = 1'b1; slow_cnt = 0;
        rd_data = '0; vec_val = 16'o001000; ncyc = 0;
        prev_bsy = 1'b1; prev_sync = 1'b1; saw_din = 1'b0; bsy_held = 1'b0;
        clear_mem();

        // Power-up: start vector read, fetch at vector & 177400
        do_reset("t1");
        check("t1_rst_sel", 32'(sel_n), 32'd3);
        check("t1_dout", 32'(dout_n), 32'd1);
        check("t1_wtbt", 32'(wtbt_n), 32'd1);
        check("t1_dmgo_hi", 32'(dmgo_n), 32'd1);
        dmgi_n = 1'b0; #1;
        check("t1_dmgo_lo", 32'(dmgo_n), 32'd0);
        dmgi_n = 1'b1;
        wait_cycles(2, "t1");
        check("t1_init_rel", 32'(init_n), 32'd1);
        check("t1_vec_addr", 32'(addr_log[0]), 32'o177716);
        check("t1_vec_sel", 32'(sel_log[0]), 32'd0);
        check("t1_fetch_addr", 32'(addr_log[1]), 32'o001000);
        check("t1_fetch_sel", 32'(sel_log[1]), 32'd1);

        // JMP -(PC) loops on itself; slave alternates fast/slow; vector low byte masked
        clear_mem();
        set_mem(0, 16'o001000, 16'o000147);
        vec_val = 16'o001377;
        alt = 1'b1; fast = 1'b1;
        do_reset("t2");
        wait_cycles(7, "t2");
        for (int i = 1; i < 7; i++) check($sformatf("t2_addr%0d", i), 32'(addr_log[i]), 32'o001000);
        for (int i = 0; i < 7; i++) check($sformatf("t2_cyc%0d", i), 32'(cyc_ok[i]), 32'd1);
        // Reset in the middle of a bus cycle releases strobes immediately
        cnt = 0;
        while (sync_n != 1'b0 && cnt < 50) begin @(negedge clk); cnt++; end
        check("t2_mid_sync_seen", 32'(sync_n), 32'd0);
        dclo = 1'b1; #1;
        check("t2_mid_sync_rel", 32'(sync_n), 32'd1);
        check("t2_mid_bsy_rel", 32'(bsy_n), 32'd1);
        check("t2_mid_init", 32'(init_n), 32'd0);
        alt = 1'b0; fast = 1'b1; vec_val = 16'o001000;

        // NOP then BR .
        clear_mem();
        set_mem(0, 16'o001000, 16'o000240);
        set_mem(1, 16'o001002, 16'o000777);
        do_reset("t3");
        wait_cycles(5, "t3");
        check("t3_a1", 32'(addr_log[1]), 32'o001000);
        check("t3_a2", 32'(addr_log[2]), 32'o001002);
        check("t3_a3", 32'(addr_log[3]), 32'o001002);
        check("t3_a4", 32'(addr_log[4]), 32'o001002);

        // JMP X(PC): 001004 + 10 = 001014
        clear_mem();
        set_mem(0, 16'o001000, 16'o000167);
        set_mem(1, 16'o001002, 16'o000010);
        set_mem(2, 16'o001014, 16'o000777);
        do_reset("t4");
        wait_cycles(5, "t4");
        check("t4_a1", 32'(addr_log[1]), 32'o001000);
        check("t4_a2", 32'(addr_log[2]), 32'o001002);
        check("t4_a3", 32'(addr_log[3]), 32'o001014);
        check("t4_a4", 32'(addr_log[4]), 32'o001014);

        // JMP @(PC)+ with an odd pointer value forced even
        clear_mem();
        set_mem(0, 16'o001000, 16'o000137);
        set_mem(1, 16'o001002, 16'o002001);
        set_mem(2, 16'o002000, 16'o000777);
        do_reset("t4b");
        wait_cycles(5, "t4b");
        check("t4b_a2", 32'(addr_log[2]), 32'o001002);
        check("t4b_a3", 32'(addr_log[3]), 32'o002000);
        check("t4b_a4", 32'(addr_log[4]), 32'o002000);

        // HALT: no more cycles until reset
        clear_mem();
        set_mem(0, 16'o001000, 16'o000000);
        do_reset("t5");
        wait_cycles(2, "t5");
        repeat (200) @(negedge clk);
        check("t5_ncyc", 32'(ncyc), 32'd2);
        check("t5_sync_idle", 32'(sync_n), 32'd1);
        check("t5_bsy_idle", 32'(bsy_n), 32'd1);
        do_reset("t5r");
        wait_cycles(1, "t5r");
        check("t5r_vec_addr", 32'(addr_log[0]), 32'o177716);

        // No reply at the vector: abort after 64 samples and stay halted
        slave_en = 1'b0;
        do_reset("t6");
        cnt = 0;
        while (din_n != 1'b0 && cnt < 50) begin @(negedge clk); cnt++; end
        check("t6_din_seen", 32'(din_n), 32'd0);
        cnt = 0;
        while (sync_n == 1'b0 && cnt < 200) begin @(negedge clk); cnt++; end
        check("t6_timeout_clks", 32'(cnt), 32'd64);
        check("t6_din_rel", 32'(din_n), 32'd1);
        check("t6_bsy_rel", 32'(bsy_n), 32'd1);
        check("t6_sel_rel", 32'(sel_n), 32'd3);
        repeat (200) @(negedge clk);
        check("t6_ncyc", 32'(ncyc), 32'd1);
        check("t6_sync_idle", 32'(sync_n), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
